// File: rtl/lsu_mem_stage.sv
// Single-entry load/store memory stage: aligns the request, issues one memory
// strobe, extends load data and holds the response until downstream accepts.
module lsu_mem_stage #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_size,
    input  logic        in_sext,
    input  logic [4:0]  in_rd,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned MASK_W = 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state;
    logic                wen_q;
    logic                sext_q;
    logic [1:0]          size_q;
    logic [LANE_W-1:0]   lane_q;
    logic [RD_W-1:0]     rd_q;

    logic                misalign_c;
    logic                illegal_c;
    logic                take_err_c;
    logic [XLEN-1:0]     eff_addr_c;
    logic [LANE_W-1:0]   lane_c;
    logic [3:0]          wmask4_c;
    logic [XLEN-1:0]     wdata_sh_c;
    logic [XLEN-1:0]     rdata_sh_c;
    logic [XLEN-1:0]     load_ext_c;

    // Request decode: alignment check, effective address and store lane placement.
    // Size 11 has no meaningful alignment, so it is rejected regardless of ERR_ON_MISALIGN.
    always_comb begin
        misalign_c = 1'b0;
        illegal_c  = 1'b0;
        eff_addr_c = in_addr;
        wmask4_c   = 4'h0;
        case (in_size)
            SZ_B: begin
                wmask4_c = 4'(4'b0001 << in_addr[1:0]);
            end
            SZ_H: begin
                misalign_c = in_addr[0];
                eff_addr_c = {in_addr[XLEN-1:1], 1'b0};
                wmask4_c   = 4'(4'b0011 << eff_addr_c[1:0]);
            end
            SZ_W: begin
                misalign_c = |in_addr[1:0];
                eff_addr_c = {in_addr[XLEN-1:2], 2'b00};
                wmask4_c   = 4'hF;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
        if (!in_wen) begin
            wmask4_c = 4'h0;
        end
        take_err_c = illegal_c | (ERR_ON_MISALIGN & misalign_c);
        lane_c     = eff_addr_c[1:0];
        wdata_sh_c = in_wdata << {lane_c, 3'b000};
    end

    // Load data: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        rdata_sh_c = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            SZ_B:    load_ext_c = {{24{sext_q & rdata_sh_c[7]}}, rdata_sh_c[7:0]};
            SZ_H:    load_ext_c = {{16{sext_q & rdata_sh_c[15]}}, rdata_sh_c[15:0]};
            default: load_ext_c = rdata_sh_c;
        endcase
    end

    // Control FSM with registered outputs; memory signals are a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            wen_q     <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= '0;
            rd_q      <= '0;
            mem_valid <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_rd    <= '0;
            out_err   <= 1'b0;
        end else begin
            mem_valid <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        wen_q    <= in_wen;
                        sext_q   <= in_sext;
                        size_q   <= in_size;
                        lane_q   <= lane_c;
                        rd_q     <= in_rd;
                        if (take_err_c) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_rdata <= '0;
                            out_rd    <= in_rd;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_wen   <= in_wen;
                            mem_raddr <= {eff_addr_c[XLEN-1:2], 2'b00};
                            mem_waddr <= {eff_addr_c[XLEN-1:2], 2'b00};
                            mem_wmask <= MASK_W'(wmask4_c);
                            mem_wdata <= in_wen ? wdata_sh_c : '0;
                        end
                    end
                end
                REQ: begin
                    if (wen_q) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_rdata <= '0;
                        out_rd    <= rd_q;
                    end else begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    state     <= RESP;
                    out_valid <= 1'b1;
                    out_err   <= 1'b0;
                    out_rdata <= load_ext_c;
                    out_rd    <= rd_q;
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_rdata <= '0;
                        out_rd    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed loads/stores, errors, stalls,
// mid-transaction reset and back-to-back issue.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [1:0]  in_size;
    logic        in_sext;
    logic [4:0]  in_rd;
    logic        mem_valid;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_err;

    lsu_mem_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wen    (in_wen),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_size   (in_size),
        .in_sext   (in_sext),
        .in_rd     (in_rd),
        .mem_valid (mem_valid),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_rd    (out_rd),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic [4:0]  rd;
        logic [31:0] mword;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        logic [31:0] maddr;
        logic [7:0]  mask;
        logic [31:0] mwdata;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vt[9];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          mv_cnt = 0;
    int          mv0;
    int          hs_k;
    int          mv_k;
    int          wait_n;
    logic        seen = 1'b0;
    logic [31:0] h_rdata;
    logic [4:0]  h_rd;
    logic        h_err;
    logic [31:0] mem_word = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_valid) mv_cnt <= mv_cnt + 1;

    // Memory model: read data is valid only in the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_valid && !mem_wen) mem_rdata <= mem_word;
        else                       mem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sext, input logic [4:0] rd,
                         input logic push, input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input logic hold);
        exp_t e;
        int   n;
        n = 0;
        in_wen = wen; in_addr = addr; in_wdata = wdata;
        in_size = size; in_sext = sext; in_rd = rd;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        if (push) begin
            e.rdata = exp_rdata; e.rd = rd; e.err = exp_err; e.lat = lat;
            sb.push_back(e);
        end
        acc_cyc = cyc;
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic chk_mem(input logic v, input logic w, input logic [31:0] a,
                           input logic [7:0] m, input logic [31:0] d);
        chk("mem_valid", 32'(mem_valid), 32'(v));
        chk("mem_wen", 32'(mem_wen), 32'(w));
        chk("mem_raddr", mem_raddr, a);
        chk("mem_waddr", mem_waddr, a);
        chk("mem_wmask", 32'(mem_wmask), 32'(m));
        chk("mem_wdata", mem_wdata, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    // Response monitor: latency on first sight, stability while stalled, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                h_rdata = out_rdata; h_rd = out_rd; h_err = out_err;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got rdata %h rd %0d err %0b want none", out_rdata, out_rd, out_err);
                end else begin
                    chk("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
                end
            end else begin
                chk("stable_rdata", out_rdata, h_rdata);
                chk("stable_rd", 32'(out_rd), 32'(h_rd));
                chk("stable_err", 32'(out_err), 32'(h_err));
            end
            if (out_ready) begin
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("resp_rdata", out_rdata, mon_e.rdata);
                    chk("resp_rd", 32'(out_rd), 32'(mon_e.rd));
                    chk("resp_err", 32'(out_err), 32'(mon_e.err));
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 32'h1000_0002, 32'h0, 2'b01, 1'b0, 5'd1, 32'h8765_4321, 32'h0000_8765, 1'b0, 3, 32'h1000_0000, 8'h00, 32'h0};
        vt[1] = '{1'b0, 32'h1000_0002, 32'h0, 2'b01, 1'b1, 5'd2, 32'h8765_4321, 32'hFFFF_8765, 1'b0, 3, 32'h1000_0000, 8'h00, 32'h0};
        vt[2] = '{1'b0, 32'h1000_0001, 32'h0, 2'b00, 1'b0, 5'd3, 32'h1122_3344, 32'h0000_0033, 1'b0, 3, 32'h1000_0000, 8'h00, 32'h0};
        vt[3] = '{1'b0, 32'h1000_0100, 32'h0, 2'b10, 1'b1, 5'd4, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3, 32'h1000_0100, 8'h00, 32'h0};
        vt[4] = '{1'b1, 32'h2000_0001, 32'h0000_00AB, 2'b00, 1'b0, 5'd6, 32'h0, 32'h0, 1'b0, 2, 32'h2000_0000, 8'h02, 32'h0000_AB00};
        vt[5] = '{1'b1, 32'h2000_0010, 32'h1234_5678, 2'b10, 1'b0, 5'd8, 32'h0, 32'h0, 1'b0, 2, 32'h2000_0010, 8'h0F, 32'h1234_5678};
        vt[6] = '{1'b0, 32'h3000_0000, 32'h0, 2'b11, 1'b0, 5'd10, 32'h0, 32'h0, 1'b1, 1, 32'h0, 8'h00, 32'h0};
        vt[7] = '{1'b1, 32'h3000_0003, 32'h0000_1234, 2'b01, 1'b0, 5'd11, 32'h0, 32'h0, 1'b1, 1, 32'h0, 8'h00, 32'h0};
        vt[8] = '{1'b0, 32'h1000_0002, 32'h0, 2'b00, 1'b1, 5'd13, 32'h007F_0000, 32'h0000_007F, 1'b0, 3, 32'h1000_0000, 8'h00, 32'h0};

        rst_n = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0;
        in_size = 2'b00; in_sext = 1'b0; in_rd = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Signed byte load from the top lane
        mem_word = 32'h8012_3456;
        issue(1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b1, 5'd5, 1'b1, 32'hFFFF_FF80, 1'b0, 3, 1'b0);
        chk_mem(1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0);
        tick();
        chk("load_pulse_end", 32'(mem_valid), 32'd0);
        drain();

        // Half store into the upper half-word
        issue(1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'b01, 1'b0, 5'd7, 1'b1, 32'h0, 1'b0, 2, 1'b0);
        chk_mem(1'b1, 1'b1, 32'h8000_0000, 8'h0C, 32'hBEEF_0000);
        tick();
        chk("store_wen_end", 32'(mem_wen), 32'd0);
        chk("store_pulse_end", 32'(mem_valid), 32'd0);
        drain();

        // Misaligned word load
        mv0 = mv_cnt;
        issue(1'b0, 32'h8000_0001, 32'h0, 2'b10, 1'b0, 5'd12, 1'b1, 32'h0, 1'b1, 1, 1'b0);
        chk("err_no_mem_valid", 32'(mem_valid), 32'd0);
        drain();
        chk("err_no_mem_count", 32'(mv_cnt - mv0), 32'd0);

        for (int i = 0; i < 9; i++) begin
            mem_word = vt[i].mword;
            issue(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].sext, vt[i].rd,
                  1'b1, vt[i].exp_rdata, vt[i].exp_err, vt[i].lat, 1'b0);
            chk_mem(!vt[i].exp_err, vt[i].wen & !vt[i].exp_err, vt[i].maddr, vt[i].mask, vt[i].mwdata);
            drain();
        end

        // Downstream stall for five cycles in RESP
        out_ready = 1'b0;
        mem_word = 32'h0000_00A5;
        issue(1'b0, 32'h0000_0040, 32'h0, 2'b00, 1'b1, 5'd14, 1'b1, 32'hFFFF_FFA5, 1'b0, 3, 1'b0);
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            tick();
            wait_n++;
        end
        repeat (5) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while capturing load data
        mv0 = mv_cnt;
        mem_word = 32'h1234_5678;
        issue(1'b0, 32'h0000_0050, 32'h0, 2'b10, 1'b0, 5'd15, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("postrst_out_valid", 32'(out_valid), 32'd0);
        end
        chk("midrst_no_retry", 32'(mv_cnt - mv0), 32'd1);
        mem_word = 32'h0BAD_F00D;
        issue(1'b0, 32'h0000_0054, 32'h0, 2'b10, 1'b0, 5'd1, 1'b1, 32'h0BAD_F00D, 1'b0, 3, 1'b0);
        drain();

        // Back-to-back with in_valid held high
        issue(1'b1, 32'h0000_0020, 32'h0000_005A, 2'b00, 1'b0, 5'd3, 1'b1, 32'h0, 1'b0, 2, 1'b1);
        chk_mem(1'b1, 1'b1, 32'h0000_0020, 8'h01, 32'h0000_005A);
        mem_word = 32'h00FF_0000;
        in_wen = 1'b0; in_addr = 32'h0000_0002; in_wdata = '0;
        in_size = 2'b01; in_sext = 1'b0; in_rd = 5'd9;
        mon_e.rdata = 32'h0000_00FF; mon_e.rd = 5'd9; mon_e.err = 1'b0; mon_e.lat = 3;
        sb.push_back(mon_e);
        hs_k = -1;
        mv_k = -1;
        for (int k = 1; k <= 20 && mv_k < 0; k++) begin
            tick();
            if (out_valid && hs_k < 0) hs_k = k;
            if (in_ready) acc_cyc = cyc;
            if (mem_valid) begin
                mv_k = k;
                in_valid = 1'b0;
            end
        end
        chk("b2b_gap", 32'(mv_k - hs_k), 32'd2);
        chk_mem(1'b1, 1'b0, 32'h0000_0000, 8'h00, 32'h0);
        drain();

        tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
